// File: rtl/bin_pkg.sv
// Shared encodings, field offsets and default widths for the per-bin
// clause / var-state / lvl-state storage.
package bin_pkg;

    localparam int unsigned NUM_CLAUSES_DEF      = 8;
    localparam int unsigned NUM_VARS_DEF         = 8;
    localparam int unsigned NUM_LVLS_DEF         = 8;
    localparam int unsigned WIDTH_LVL_DEF        = 16;
    localparam int unsigned WIDTH_BIN_ID_DEF     = 10;
    localparam int unsigned WIDTH_VAR_STATES_DEF = 2 + 1 + WIDTH_LVL_DEF;
    localparam int unsigned WIDTH_LVL_STATES_DEF = WIDTH_BIN_ID_DEF + 1;

    typedef enum logic [1:0] {
        LIT_ABSENT = 2'b00,
        LIT_POS    = 2'b01,
        LIT_NEG    = 2'b10,
        LIT_RSVD   = 2'b11
    } lit_e;

    typedef enum logic [1:0] {
        VAL_UNASSIGNED = 2'b00,
        VAL_FALSE      = 2'b01,
        VAL_TRUE       = 2'b10,
        VAL_RSVD       = 2'b11
    } val_e;

    // Var-state: {value[1:0], implied, level[width_lvl-1:0]}
    localparam int unsigned VS_LEVEL_LSB = 0;

    function automatic int unsigned vs_implied_bit(input int unsigned width_lvl);
        return width_lvl;
    endfunction

    function automatic int unsigned vs_value_lsb(input int unsigned width_lvl);
        return width_lvl + 1;
    endfunction

    // Lvl-state: {dcd_bin, has_bkt}
    localparam int unsigned LS_HAS_BKT_BIT = 0;
    localparam int unsigned LS_DCD_BIN_LSB = 1;

endpackage

// File: rtl/clause_lit_decoder.sv
// Decodes a 2-bit-per-variable clause into presence / polarity masks and a
// literal count. Reserved encodings decode as absent.
module clause_lit_decoder
    import bin_pkg::*;
#(
    parameter int unsigned NUM_VARS = NUM_VARS_DEF
) (
    input  logic [2*NUM_VARS-1:0]      clause,
    output logic [NUM_VARS-1:0]        lit_valid,
    output logic [NUM_VARS-1:0]        lit_neg,
    output logic [$clog2(NUM_VARS):0]  lit_cnt
);

    localparam int unsigned CNT_W = $clog2(NUM_VARS) + 1;

    always_comb begin
        lit_valid = '0;
        lit_neg   = '0;
        for (int unsigned k = 0; k < NUM_VARS; k++) begin
            case (lit_e'(clause[2*k +: 2]))
                LIT_POS: lit_valid[k] = 1'b1;
                LIT_NEG: begin
                    lit_valid[k] = 1'b1;
                    lit_neg[k]   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        lit_cnt = '0;
        for (int unsigned k = 0; k < NUM_VARS; k++) begin
            lit_cnt = lit_cnt + CNT_W'(lit_valid[k]);
        end
    end

endmodule

// File: rtl/bin_list_store.sv
// Per-bin register file for clauses, var states and lvl states with
// combinational decoded read ports.
module bin_list_store
    import bin_pkg::*;
#(
    parameter int unsigned NUM_CLAUSES_A_BIN = NUM_CLAUSES_DEF,
    parameter int unsigned NUM_VARS_A_BIN    = NUM_VARS_DEF,
    parameter int unsigned NUM_LVLS_A_BIN    = NUM_LVLS_DEF,
    parameter int unsigned WIDTH_LVL         = WIDTH_LVL_DEF,
    parameter int unsigned WIDTH_BIN_ID      = WIDTH_BIN_ID_DEF,
    parameter int unsigned WIDTH_VAR_STATES  = WIDTH_VAR_STATES_DEF,
    parameter int unsigned WIDTH_LVL_STATES  = WIDTH_LVL_STATES_DEF
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_CLAUSES_A_BIN-1:0]                wr_carray_i,
    input  logic [NUM_VARS_A_BIN*2-1:0]                 clause_i,
    input  logic [NUM_VARS_A_BIN-1:0]                   wr_var_states_i,
    input  logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0]  vars_states_i,
    input  logic [NUM_LVLS_A_BIN-1:0]                   wr_lvl_states_i,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS_A_BIN-1:0]  lvl_states_i,
    input  logic [$clog2(NUM_CLAUSES_A_BIN)-1:0]        c_idx_i,
    input  logic [$clog2(NUM_VARS_A_BIN)-1:0]           v_idx_i,
    input  logic [$clog2(NUM_LVLS_A_BIN)-1:0]           l_idx_i,
    output logic [NUM_VARS_A_BIN*2-1:0]                 clause_o,
    output logic [NUM_VARS_A_BIN-1:0]                   lit_valid_o,
    output logic [NUM_VARS_A_BIN-1:0]                   lit_neg_o,
    output logic [$clog2(NUM_VARS_A_BIN):0]             lit_cnt_o,
    output logic [1:0]                                  var_value_o,
    output logic                                        var_implied_o,
    output logic [WIDTH_LVL-1:0]                        var_level_o,
    output logic [$clog2(NUM_VARS_A_BIN):0]             assigned_cnt_o,
    output logic [WIDTH_BIN_ID-1:0]                     dcd_bin_o,
    output logic                                        has_bkt_o
);

    localparam int unsigned CI_W        = $clog2(NUM_CLAUSES_A_BIN);
    localparam int unsigned VI_W        = $clog2(NUM_VARS_A_BIN);
    localparam int unsigned LI_W        = $clog2(NUM_LVLS_A_BIN);
    localparam int unsigned CNT_W       = $clog2(NUM_VARS_A_BIN) + 1;
    localparam int unsigned IMPLIED_BIT = vs_implied_bit(WIDTH_LVL);
    localparam int unsigned VALUE_LSB   = vs_value_lsb(WIDTH_LVL);

    logic [NUM_CLAUSES_A_BIN-1:0][NUM_VARS_A_BIN*2-1:0] carray;
    logic [NUM_VARS_A_BIN-1:0][WIDTH_VAR_STATES-1:0]    var_states;
    logic [NUM_LVLS_A_BIN-1:0][WIDTH_LVL_STATES-1:0]    lvl_states;

    logic [NUM_VARS_A_BIN*2-1:0] clause_sel;
    logic [WIDTH_VAR_STATES-1:0] var_sel;
    logic [WIDTH_LVL_STATES-1:0] lvl_sel;

    always_ff @(posedge clk) begin
        if (!rst) begin
            carray     <= '0;
            var_states <= '0;
            lvl_states <= '0;
        end else begin
            for (int unsigned j = 0; j < NUM_CLAUSES_A_BIN; j++) begin
                if (wr_carray_i[j]) carray[j] <= clause_i;
            end
            for (int unsigned i = 0; i < NUM_VARS_A_BIN; i++) begin
                if (wr_var_states_i[i])
                    var_states[i] <= vars_states_i[i*WIDTH_VAR_STATES +: WIDTH_VAR_STATES];
            end
            for (int unsigned i = 0; i < NUM_LVLS_A_BIN; i++) begin
                if (wr_lvl_states_i[i])
                    lvl_states[i] <= lvl_states_i[i*WIDTH_LVL_STATES +: WIDTH_LVL_STATES];
            end
        end
    end

    // Index-compare muxes: indices past the entry count match nothing and read 0.
    always_comb begin
        clause_sel = '0;
        for (int unsigned j = 0; j < NUM_CLAUSES_A_BIN; j++) begin
            if (c_idx_i == CI_W'(j)) clause_sel = carray[j];
        end
    end

    always_comb begin
        var_sel = '0;
        for (int unsigned i = 0; i < NUM_VARS_A_BIN; i++) begin
            if (v_idx_i == VI_W'(i)) var_sel = var_states[i];
        end
    end

    always_comb begin
        lvl_sel = '0;
        for (int unsigned i = 0; i < NUM_LVLS_A_BIN; i++) begin
            if (l_idx_i == LI_W'(i)) lvl_sel = lvl_states[i];
        end
    end

    always_comb begin
        assigned_cnt_o = '0;
        for (int unsigned i = 0; i < NUM_VARS_A_BIN; i++) begin
            if (var_states[i][VALUE_LSB +: 2] != VAL_UNASSIGNED)
                assigned_cnt_o = assigned_cnt_o + CNT_W'(1);
        end
    end

    assign clause_o      = clause_sel;
    assign var_value_o   = var_sel[VALUE_LSB +: 2];
    assign var_implied_o = var_sel[IMPLIED_BIT];
    assign var_level_o   = var_sel[VS_LEVEL_LSB +: WIDTH_LVL];
    assign dcd_bin_o     = lvl_sel[LS_DCD_BIN_LSB +: WIDTH_BIN_ID];
    assign has_bkt_o     = lvl_sel[LS_HAS_BKT_BIT];

    clause_lit_decoder #(
        .NUM_VARS (NUM_VARS_A_BIN)
    ) u_lit_dec (
        .clause    (clause_sel),
        .lit_valid (lit_valid_o),
        .lit_neg   (lit_neg_o),
        .lit_cnt   (lit_cnt_o)
    );

endmodule

// File: tb/tb_bin_list_store.sv
// Self-checking bench for bin_list_store: directed table, hand-written
// corner sequences and randomized traffic against a reference model.
module tb_bin_list_store;

    localparam int NC  = 8;
    localparam int NV  = 8;
    localparam int NL  = 8;
    localparam int WL  = 16;
    localparam int WB  = 10;
    localparam int WVS = 19;
    localparam int WLS = 11;

    logic             clk = 1'b0;
    logic             rst;
    logic [NC-1:0]    wr_carray_i;
    logic [2*NV-1:0]  clause_i;
    logic [NV-1:0]    wr_var_states_i;
    logic [WVS*NV-1:0] vars_states_i;
    logic [NL-1:0]    wr_lvl_states_i;
    logic [WLS*NL-1:0] lvl_states_i;
    logic [2:0]       c_idx_i, v_idx_i, l_idx_i;
    logic [2*NV-1:0]  clause_o;
    logic [NV-1:0]    lit_valid_o, lit_neg_o;
    logic [3:0]       lit_cnt_o;
    logic [1:0]       var_value_o;
    logic             var_implied_o;
    logic [WL-1:0]    var_level_o;
    logic [3:0]       assigned_cnt_o;
    logic [WB-1:0]    dcd_bin_o;
    logic             has_bkt_o;

    bin_list_store #(
        .NUM_CLAUSES_A_BIN (NC),
        .NUM_VARS_A_BIN    (NV),
        .NUM_LVLS_A_BIN    (NL),
        .WIDTH_LVL         (WL),
        .WIDTH_BIN_ID      (WB),
        .WIDTH_VAR_STATES  (WVS),
        .WIDTH_LVL_STATES  (WLS)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .wr_carray_i     (wr_carray_i),
        .clause_i        (clause_i),
        .wr_var_states_i (wr_var_states_i),
        .vars_states_i   (vars_states_i),
        .wr_lvl_states_i (wr_lvl_states_i),
        .lvl_states_i    (lvl_states_i),
        .c_idx_i         (c_idx_i),
        .v_idx_i         (v_idx_i),
        .l_idx_i         (l_idx_i),
        .clause_o        (clause_o),
        .lit_valid_o     (lit_valid_o),
        .lit_neg_o       (lit_neg_o),
        .lit_cnt_o       (lit_cnt_o),
        .var_value_o     (var_value_o),
        .var_implied_o   (var_implied_o),
        .var_level_o     (var_level_o),
        .assigned_cnt_o  (assigned_cnt_o),
        .dcd_bin_o       (dcd_bin_o),
        .has_bkt_o       (has_bkt_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [15:0] m_clause [NC];
    logic [18:0] m_var    [NV];
    logic [10:0] m_lvl    [NL];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock edge; the model takes the inputs as they stand at the edge.
    task automatic step();
        @(posedge clk);
        for (int i = 0; i < NC; i++) begin
            if (!rst) m_clause[i] = '0;
            else if (wr_carray_i[i]) m_clause[i] = clause_i;
        end
        for (int i = 0; i < NV; i++) begin
            if (!rst) m_var[i] = '0;
            else if (wr_var_states_i[i]) m_var[i] = vars_states_i[i*WVS +: WVS];
        end
        for (int i = 0; i < NL; i++) begin
            if (!rst) m_lvl[i] = '0;
            else if (wr_lvl_states_i[i]) m_lvl[i] = lvl_states_i[i*WLS +: WLS];
        end
        #1;
    endtask

    task automatic no_writes();
        wr_carray_i     = '0;
        wr_var_states_i = '0;
        wr_lvl_states_i = '0;
    endtask

    task automatic check_model(input string tag);
        logic [15:0] c;
        logic [7:0]  v, n;
        int          cnt, asg, f;
        logic [18:0] vs;
        logic [10:0] ls;
        c = m_clause[c_idx_i];
        v = '0; n = '0; cnt = 0; asg = 0;
        for (int k = 0; k < NV; k++) begin
            f = int'((c >> (2 * k)) & 16'h3);
            if (f == 1) begin v[k] = 1'b1; cnt++; end
            if (f == 2) begin v[k] = 1'b1; n[k] = 1'b1; cnt++; end
        end
        for (int i = 0; i < NV; i++) if (m_var[i] >= 19'h20000) asg++;
        vs = m_var[v_idx_i];
        ls = m_lvl[l_idx_i];
        chk({tag, ".clause"},   64'(clause_o),       64'(c));
        chk({tag, ".valid"},    64'(lit_valid_o),    64'(v));
        chk({tag, ".neg"},      64'(lit_neg_o),      64'(n));
        chk({tag, ".lit_cnt"},  64'(lit_cnt_o),      64'(cnt));
        chk({tag, ".value"},    64'(var_value_o),    64'(vs / 19'h20000));
        chk({tag, ".implied"},  64'(var_implied_o),  64'((vs / 19'h10000) % 2));
        chk({tag, ".level"},    64'(var_level_o),    64'(vs % 19'h10000));
        chk({tag, ".assigned"}, 64'(assigned_cnt_o), 64'(asg));
        chk({tag, ".dcd_bin"},  64'(dcd_bin_o),      64'(ls / 11'd2));
        chk({tag, ".has_bkt"},  64'(has_bkt_o),      64'(ls % 11'd2));
    endtask

    typedef struct {
        logic [7:0]  wc;
        logic [15:0] cd;
        logic [7:0]  wv;
        logic [18:0] vd;
        logic [7:0]  wl;
        logic [10:0] ld;
        logic [2:0]  ci, vi, li;
        logic [15:0] e_clause;
        logic [7:0]  e_valid, e_neg;
        logic [3:0]  e_cnt;
        logic [1:0]  e_val;
        logic        e_imp;
        logic [15:0] e_lvl;
        logic [3:0]  e_asg;
        logic [9:0]  e_dcd;
        logic        e_bkt;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{8'h04, 16'h0021, 8'h08, {2'b10, 1'b1, 16'd5}, 8'h01, {10'd7, 1'b1}, 3'd2, 3'd3, 3'd0,
                    16'h0021, 8'h05, 8'h04, 4'd2, 2'b10, 1'b1, 16'd5, 4'd1, 10'd7, 1'b1};
        vecs[1] = '{8'h00, 16'h0000, 8'h00, 19'd0, 8'h00, 11'd0, 3'd0, 3'd0, 3'd1,
                    16'h0000, 8'h00, 8'h00, 4'd0, 2'b00, 1'b0, 16'd0, 4'd1, 10'd0, 1'b0};
        vecs[2] = '{8'h02, 16'h0003, 8'h01, {2'b11, 1'b0, 16'hFFFF}, 8'h20, {10'h3FF, 1'b0}, 3'd1, 3'd0, 3'd5,
                    16'h0003, 8'h00, 8'h00, 4'd0, 2'b11, 1'b0, 16'hFFFF, 4'd2, 10'h3FF, 1'b0};
        vecs[3] = '{8'hC0, 16'h5A5A, 8'h81, {2'b01, 1'b0, 16'd100}, 8'h00, 11'd0, 3'd7, 3'd7, 3'd5,
                    16'h5A5A, 8'hFF, 8'h33, 4'd8, 2'b01, 1'b0, 16'd100, 4'd3, 10'h3FF, 1'b0};
        vecs[4] = '{8'h80, 16'h0000, 8'h00, 19'd0, 8'h00, 11'd0, 3'd6, 3'd0, 3'd0,
                    16'h5A5A, 8'hFF, 8'h33, 4'd8, 2'b01, 1'b0, 16'd100, 4'd3, 10'd7, 1'b1};
        vecs[5] = '{8'h00, 16'h0000, 8'h08, {2'b00, 1'b1, 16'd9}, 8'h00, 11'd0, 3'd7, 3'd3, 3'd1,
                    16'h0000, 8'h00, 8'h00, 4'd0, 2'b00, 1'b1, 16'd9, 4'd2, 10'd0, 1'b0};

        // Reset for two cycles
        rst = 1'b0;
        no_writes();
        clause_i = '0; vars_states_i = '0; lvl_states_i = '0;
        c_idx_i = '0; v_idx_i = '0; l_idx_i = '0;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("reset.clause",   64'(clause_o),       64'd0);
        chk("reset.lit_cnt",  64'(lit_cnt_o),      64'd0);
        chk("reset.assigned", 64'(assigned_cnt_o), 64'd0);
        chk("reset.dcd_bin",  64'(dcd_bin_o),      64'd0);
        check_model("reset");

        // Directed table: write cycle, then read with strobes low
        foreach (vecs[t]) begin
            wr_carray_i     = vecs[t].wc;
            clause_i        = vecs[t].cd;
            wr_var_states_i = vecs[t].wv;
            wr_lvl_states_i = vecs[t].wl;
            for (int i = 0; i < NV; i++)
                vars_states_i[i*WVS +: WVS] = vecs[t].wv[i] ? vecs[t].vd : 19'($urandom);
            for (int i = 0; i < NL; i++)
                lvl_states_i[i*WLS +: WLS] = vecs[t].wl[i] ? vecs[t].ld : 11'($urandom);
            step();
            no_writes();
            c_idx_i = vecs[t].ci; v_idx_i = vecs[t].vi; l_idx_i = vecs[t].li;
            #1;
            chk($sformatf("vec%0d.clause", t),   64'(clause_o),       64'(vecs[t].e_clause));
            chk($sformatf("vec%0d.valid", t),    64'(lit_valid_o),    64'(vecs[t].e_valid));
            chk($sformatf("vec%0d.neg", t),      64'(lit_neg_o),      64'(vecs[t].e_neg));
            chk($sformatf("vec%0d.lit_cnt", t),  64'(lit_cnt_o),      64'(vecs[t].e_cnt));
            chk($sformatf("vec%0d.value", t),    64'(var_value_o),    64'(vecs[t].e_val));
            chk($sformatf("vec%0d.implied", t),  64'(var_implied_o),  64'(vecs[t].e_imp));
            chk($sformatf("vec%0d.level", t),    64'(var_level_o),    64'(vecs[t].e_lvl));
            chk($sformatf("vec%0d.assigned", t), 64'(assigned_cnt_o), 64'(vecs[t].e_asg));
            chk($sformatf("vec%0d.dcd_bin", t),  64'(dcd_bin_o),      64'(vecs[t].e_dcd));
            chk($sformatf("vec%0d.has_bkt", t),  64'(has_bkt_o),      64'(vecs[t].e_bkt));
        end

        // Write and read the same entry: old value now, new value next cycle
        c_idx_i     = 3'd1;
        wr_carray_i = 8'h02;
        clause_i    = 16'h0006;
        #1;
        chk("rdold.clause_before", 64'(clause_o),  64'h0003);
        chk("rdold.cnt_before",    64'(lit_cnt_o), 64'd0);
        step();
        no_writes();
        #1;
        chk("rdold.clause_after", 64'(clause_o),    64'h0006);
        chk("rdold.valid_after",  64'(lit_valid_o), 64'h03);
        chk("rdold.neg_after",    64'(lit_neg_o),   64'h01);
        chk("rdold.cnt_after",    64'(lit_cnt_o),   64'd2);

        // Reset together with every strobe: reset wins
        rst = 1'b0;
        wr_carray_i = '1; wr_var_states_i = '1; wr_lvl_states_i = '1;
        clause_i = '1; vars_states_i = '1; lvl_states_i = '1;
        step();
        rst = 1'b1;
        no_writes();
        for (int i = 0; i < 8; i++) begin
            c_idx_i = 3'(i); v_idx_i = 3'(i); l_idx_i = 3'(i);
            #1;
            chk($sformatf("rstwin%0d.clause", i),   64'(clause_o),       64'd0);
            chk($sformatf("rstwin%0d.value", i),    64'(var_value_o),    64'd0);
            chk($sformatf("rstwin%0d.level", i),    64'(var_level_o),    64'd0);
            chk($sformatf("rstwin%0d.implied", i),  64'(var_implied_o),  64'd0);
            chk($sformatf("rstwin%0d.dcd_bin", i),  64'(dcd_bin_o),      64'd0);
            chk($sformatf("rstwin%0d.has_bkt", i),  64'(has_bkt_o),      64'd0);
            chk($sformatf("rstwin%0d.assigned", i), 64'(assigned_cnt_o), 64'd0);
        end

        // Randomized traffic against the reference model
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst             = ($urandom_range(0, 39) != 0);
            wr_carray_i     = 8'($urandom & $urandom);
            wr_var_states_i = 8'($urandom & $urandom);
            wr_lvl_states_i = 8'($urandom & $urandom);
            clause_i        = 16'($urandom);
            for (int i = 0; i < NV; i++) vars_states_i[i*WVS +: WVS] = 19'($urandom);
            for (int i = 0; i < NL; i++) lvl_states_i[i*WLS +: WLS]  = 11'($urandom);
            c_idx_i = 3'($urandom); v_idx_i = 3'($urandom); l_idx_i = 3'($urandom);
            #1;
            check_model($sformatf("rand%0d", cyc));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
